mem_pattern_master: RTL

Self-checking initiator for the memory valid/ready interface. On a start pulse it writes a seed-derived pattern to every address 0..DEPTH-1, reads each address back, compares, and reports an error count and the first failing address. It drives the same wr_rd/addr/wdata/valid pins that `memory` responds on. It is used as an on-chip memory checker and as the active end of memory-interface integration benches.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_stall_watchdog.sv | 40 ++++
 rtl/mem_pattern_master.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory pattern master:
//   - state_t     : master FSM states (IDLE, WR, RD, DONE)
//   - WR_OP/RD_OP : encodings of the wr_rd request pin
//   - pat()       : test pattern, seed + address modulo 2^32. Callers truncate
//                   the result to their data width, so any WIDTH <= 32 works.
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic WR_OP = 1'b1;
  localparam logic RD_OP = 1'b0;

  // The low WIDTH bits of the 32-bit sum equal (seed + addr) mod 2^WIDTH.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/mem_stall_watchdog.sv
// -----------------------------------------------------------------------------
// mem_stall_watchdog
// Counts consecutive stall cycles. The count saturates at TIMEOUT_CYCLES.
// Ports:
//   clk     in  clock, rising edge
//   res     in  synchronous active-low reset
//   en      in  stall this cycle (valid && !ready)
//   clear   in  restart the count (beat completed, or master idle)
//   expired out count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module mem_stall_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Stall counter: clear has priority; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != CW'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = (r_cnt == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_pattern_master.sv
// -----------------------------------------------------------------------------
// mem_pattern_master
// Self-checking memory initiator. After a start pulse it writes pat(a) to every
// address 0..DEPTH-1, then reads each address back and compares. It reports the
// mismatch count and the first failing address.
//
// Optional build macro: MEM_MASTER_TIMEOUT_EN. When defined, the master aborts
// to DONE (and sets timeout) after TIMEOUT_CYCLES stalled cycles. When not
// defined, the master waits on ready indefinitely and timeout stays 0.
//
// Ports:
//   clk, res           clock and synchronous active-low reset
//   start, seed        start request (sampled in IDLE) and pattern seed
//   wr_rd, addr, wdata request: direction (1 = write), address, write data
//   valid / ready      handshake; a beat completes when both are high
//   rdata              read data, sampled on a read beat
//   busy, done         busy in every state except IDLE; done is a 1-cycle end pulse
//   err_cnt            number of read mismatches
//   first_err_addr     address of the first mismatch
//   timeout            sticky flag: the last test aborted on a stall
// -----------------------------------------------------------------------------
module mem_pattern_master
  import mem_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  state_t                r_state;
  logic [WIDTH-1:0]      r_seed_q;
  logic                  r_wr_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH:0]   r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_timeout;

  logic                  w_beat;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [WIDTH-1:0]      w_rd_exp;
  logic [WIDTH-1:0]      w_wdata_next;
  logic                  w_expired;

  assign w_beat       = r_valid && ready;
  assign w_last       = (r_addr == ADDR_WIDTH'(DEPTH - 1));
  assign w_addr_inc   = r_addr + ADDR_WIDTH'(1);
  assign w_rd_exp     = WIDTH'(pat(32'(r_seed_q), 32'(r_addr)));
  assign w_wdata_next = WIDTH'(pat(32'(r_seed_q), 32'(w_addr_inc)));

`ifdef MEM_MASTER_TIMEOUT_EN
  logic w_stall;
  logic w_wd_clear;

  assign w_stall    = r_valid && !ready;
  // The count also restarts while idle, so a previous abort cannot leak
  // into the next test.
  assign w_wd_clear = w_beat || !r_busy;

  mem_stall_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .res     (res),
    .en      (w_stall),
    .clear   (w_wd_clear),
    .expired (w_expired)
  );
`else
  // Never expires. The comparison is constant 0 for any legal limit.
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  // Master FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_state          <= IDLE;
      r_seed_q         <= '0;
      r_wr_rd          <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_valid          <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_timeout        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state          <= WR;
            r_seed_q         <= seed;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_timeout        <= 1'b0;
            r_valid          <= 1'b1;
            r_busy           <= 1'b1;
            r_wr_rd          <= WR_OP;
            r_addr           <= '0;
            r_wdata          <= WIDTH'(pat(32'(seed), 32'd0));
          end else begin
            r_state <= IDLE;
          end
        end
        WR: begin
          if (w_beat) begin
            if (w_last) begin
              r_state <= RD;
              r_wr_rd <= RD_OP;
              r_addr  <= '0;
              r_wdata <= '0;
            end else begin
              r_addr  <= w_addr_inc;
              r_wdata <= w_wdata_next;
            end
          end else if (w_expired) begin
            r_state   <= DONE;
            r_valid   <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_state <= WR;
          end
        end
        RD: begin
          if (w_beat) begin
            if (rdata != w_rd_exp) begin
              r_err_cnt <= r_err_cnt + (ADDR_WIDTH + 1)'(1);
              if (r_err_cnt == '0) begin
                r_first_err_addr <= r_addr;
              end else begin
                r_first_err_addr <= r_first_err_addr;
              end
            end else begin
              r_err_cnt <= r_err_cnt;
            end
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_addr  <= '0;
            end else begin
              r_addr <= w_addr_inc;
            end
          end else if (w_expired) begin
            r_state   <= DONE;
            r_valid   <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_state <= RD;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_rd          = r_wr_rd;
  assign addr           = r_addr;
  assign wdata          = r_wdata;
  assign valid          = r_valid;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;
  assign timeout        = r_timeout;

endmodule
